vec_ram_burst_master: RTL

Burst initiator for the `vec_ram` native port: 1 cycle latency on synchronous reads, byte-enabled writes. It accepts one burst command at a time from an accelerator-side client (base address, beat count, direction) and sequences per-beat RAM accesses. Write data is streamed in over a valid/ready channel. Read data is returned over a valid/ready channel with backpressure, absorbed by a 2-entry credit-controlled buffer. It sits between compute/DMA logic and `vec_ram`, driving `en_i`, `we_i`, `addr_i` and `d_i`, and consuming `d_o`.

---
 rtl/vec_ram_burst_master.sv | 107 ++++++++++
 1 files changed

// File: rtl/vec_ram_burst_master.sv
// vec_ram_burst_master: burst sequencer for vec_ram with streamed writes and credit-buffered reads
module vec_ram_burst_master #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 256,
   parameter int BE_W   = DATA_W/8,
   parameter int LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic              wdata_valid_i,
   output logic              wdata_ready_o,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [BE_W-1:0]   wstrb_i,
   output logic              rdata_valid_o,
   input  logic              rdata_ready_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ram_en_o,
   output logic [BE_W-1:0]   ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_d_o,
   input  logic [DATA_W-1:0] ram_d_i
);
   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len, pop_cnt;
   logic [LEN_W:0]    cnt;
   logic              inflight, wptr, rptr;
   logic [1:0]        fifo_cnt;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              cmd_fire, beat, issue, pop, last_beat, last_pop;
   logic [2:0]        occ;
   assign rdata_valid_o = fifo_cnt != 2'd0;
   assign rdata_o       = fifo_mem[rptr];
   assign rdata_last_o  = rdata_valid_o && pop_cnt == len;
   assign busy_o        = state != IDLE;
   assign done_o        = state == DONE;
   assign ram_addr_o    = addr;
   // handshakes, read credit check (in-flight + buffered after this cycle's pop), RAM drive and next state
   always_comb begin
      cmd_ready_o   = state == IDLE;
      wdata_ready_o = state == WR;
      cmd_fire      = cmd_valid_i && cmd_ready_o;
      beat          = wdata_ready_o && wdata_valid_i;
      pop           = rdata_valid_o && rdata_ready_i;
      occ           = {2'b0, inflight} + {1'b0, fifo_cnt} - {2'b0, pop};
      issue         = state == RD && cnt <= {1'b0, len} && occ < 3'd2;
      last_beat     = beat && cnt == {1'b0, len};
      last_pop      = pop && pop_cnt == len;
      ram_en_o      = beat || issue;
      ram_we_o      = beat ? wstrb_i : '0;
      ram_d_o       = beat ? wdata_i : '0;
      state_nxt     = state == IDLE ? (cmd_fire ? (cmd_we_i ? WR : RD) : IDLE) :
                      state == DONE ? IDLE :
                      (last_beat || last_pop) ? DONE : state;
   end
   // state, command latch, address and beat/issue/pop counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         addr     <= '0;
         len      <= '0;
         cnt      <= '0;
         pop_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (cmd_fire) begin
            addr    <= cmd_addr_i;
            len     <= cmd_len_i;
            cnt     <= '0;
            pop_cnt <= '0;
         end else begin
            if (beat || issue) begin
               addr <= addr + 1'b1;
               cnt  <= cnt + 1'b1;
            end
            if (pop) pop_cnt <= pop_cnt + 1'b1;
         end
      end
   end
   // two-entry return buffer: push the cycle after an issue, pop on rdata handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_mem <= '{default: '0};
         wptr     <= 1'b0;
         rptr     <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_mem[wptr] <= ram_d_i;
            wptr           <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      end
   end
endmodule
